// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame exposure, readout trigger, readout handshake and gap loop.
module frame_sequencer #(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic        CLK,
   input  logic        rst,
   input  logic        start_i,
   input  logic        stop_i,
   input  logic [31:0] T_EXP,
   input  logic [31:0] T_GAP,
   input  logic [31:0] NUM_FRAME,
   input  logic        re_busy_i,
   output logic        trigger_o,
   output logic        exp_active,
   output logic        seq_busy,
   output logic        seq_done,
   output logic [31:0] frame_cnt,
   output logic        ack_err
);
   localparam logic [31:0] ACK_LAST = 32'(ACK_TIMEOUT - 1);
   typedef enum logic [2:0] {IDLE, EXPOSE, TRIG, WAIT_ACK, WAIT_RO, GAP} state_t;
   state_t      state_q, state_d;
   logic [31:0] timer_q, texp_q, tgap_q, nfr_q;
   logic        stop_pending_q, last, ro_done;
   assign last    = (nfr_q != 32'd0) && (frame_cnt + 32'd1 == nfr_q);
   assign ro_done = (state_q == WAIT_RO) && !re_busy_i;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     state_d = start_i ? EXPOSE : IDLE;
         EXPOSE:   state_d = stop_i ? IDLE : (timer_q >= texp_q - 32'd1) ? TRIG : EXPOSE;
         TRIG:     state_d = WAIT_ACK;
         WAIT_ACK: state_d = re_busy_i ? WAIT_RO : (timer_q >= ACK_LAST) ? IDLE : WAIT_ACK;
         WAIT_RO:  state_d = re_busy_i ? WAIT_RO : (last || stop_pending_q || stop_i) ? IDLE
                             : (tgap_q == 32'd0) ? EXPOSE : GAP;
         GAP:      state_d = stop_i ? IDLE : (timer_q >= tgap_q - 32'd1) ? EXPOSE : GAP;
         default:  state_d = IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q        <= IDLE;
         timer_q        <= '0;
         texp_q         <= '0;
         tgap_q         <= '0;
         nfr_q          <= '0;
         stop_pending_q <= 1'b0;
         trigger_o      <= 1'b0;
         exp_active     <= 1'b0;
         seq_busy       <= 1'b0;
         seq_done       <= 1'b0;
         frame_cnt      <= '0;
         ack_err        <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= (state_d != state_q) ? 32'd0 : timer_q + 32'd1;
         trigger_o  <= state_d == TRIG;
         exp_active <= state_d == EXPOSE;
         seq_busy   <= state_d != IDLE;
         seq_done   <= (state_q != IDLE) && (state_d == IDLE);
         // the in-flight frame always finishes; a late stop only ends the sequence afterwards
         stop_pending_q <= (state_d == IDLE) ? 1'b0
                           : (stop_i && (state_q inside {TRIG, WAIT_ACK, WAIT_RO})) ? 1'b1
                           : stop_pending_q;
         if (state_q == IDLE && start_i) begin
            texp_q    <= (T_EXP == 32'd0) ? 32'd1 : T_EXP;
            tgap_q    <= T_GAP;
            nfr_q     <= NUM_FRAME;
            frame_cnt <= '0;
            ack_err   <= 1'b0;
         end
         if (ro_done)
            frame_cnt <= frame_cnt + 32'd1;
         if (state_q == WAIT_ACK && state_d == IDLE)
            ack_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed scenarios with a scoreboard checked at every seq_done.
module tb_frame_sequencer;
   logic        CLK, rst, start_i, stop_i, re_busy_i;
   logic [31:0] T_EXP, T_GAP, NUM_FRAME, frame_cnt;
   logic        trigger_o, exp_active, seq_busy, seq_done, ack_err;

   frame_sequencer #(.ACK_TIMEOUT(16)) dut (
      .CLK(CLK), .rst(rst), .start_i(start_i), .stop_i(stop_i),
      .T_EXP(T_EXP), .T_GAP(T_GAP), .NUM_FRAME(NUM_FRAME), .re_busy_i(re_busy_i),
      .trigger_o(trigger_o), .exp_active(exp_active), .seq_busy(seq_busy),
      .seq_done(seq_done), .frame_cnt(frame_cnt), .ack_err(ack_err)
   );

   typedef struct {int frames; int ack; int trigs; int exp_len;} exp_t;
   exp_t q[$];
   int total = 0, bad = 0, trig_total = 0;
   logic ro_on;
   int dly, hold;

   initial begin
      CLK = 0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   // readout model: busy rises 2 cycles after it samples trigger and stays up 10 cycles
   always @(posedge CLK) begin
      if (rst) begin
         re_busy_i <= 1'b0;
         dly <= 0;
         hold <= 0;
      end else if (trigger_o && ro_on) begin
         dly <= 2;
      end else if (dly != 0) begin
         dly <= dly - 1;
         if (dly == 1) begin
            re_busy_i <= 1'b1;
            hold <= 10;
         end
      end else if (re_busy_i) begin
         if (hold > 1) hold <= hold - 1;
         else re_busy_i <= 1'b0;
      end
   end

   // monitor: gathers per-sequence statistics and pops the scoreboard on seq_done
   initial begin
      logic busy_p = 0, trig_p = 0, exp_p = 0;
      logic [31:0] fc_p = 0;
      int trigs = 0, trig_cyc = 0, exp_run = 0, exp_min = 0, exp_max = 0;
      exp_t e;
      forever begin
         @(negedge CLK);
         if (seq_busy && !busy_p) begin
            trigs = 0; trig_cyc = 0; exp_min = 1 << 30; exp_max = 0;
         end
         if (trigger_o) begin
            trig_cyc++;
            if (!trig_p) begin trigs++; trig_total++; end
         end
         if (exp_active) exp_run++;
         else if (exp_p) begin
            if (exp_run < exp_min) exp_min = exp_run;
            if (exp_run > exp_max) exp_max = exp_run;
            exp_run = 0;
         end
         if (frame_cnt != fc_p && frame_cnt != 0) chk("frame_step", frame_cnt, fc_p + 1);
         if (seq_done) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_done actual=1 required=0 frame_cnt=%0d", frame_cnt);
            end else begin
               e = q.pop_front();
               chk("frames", frame_cnt, e.frames);
               chk("ack_err", {31'b0, ack_err}, e.ack);
               chk("trig_count", trigs, e.trigs);
               chk("trig_width", trig_cyc, e.trigs);
               chk("busy_at_done", {31'b0, seq_busy}, 0);
               if (e.exp_len != 0) begin
                  chk("exp_min", exp_min, e.exp_len);
                  chk("exp_max", exp_max, e.exp_len);
               end
            end
         end
         busy_p = seq_busy; trig_p = trigger_o; exp_p = exp_active; fc_p = frame_cnt;
      end
   end

   function automatic logic sel(input int s);
      return s == 0 ? seq_done : s == 1 ? trigger_o : s == 2 ? re_busy_i : !re_busy_i;
   endfunction

   task automatic wait_for(input int s, input int budget, input string nm);
      int n = 0;
      do begin @(negedge CLK); n++; end while (!sel(s) && n < budget);
      if (!sel(s)) begin
         total++; bad++;
         $display("FAIL %s timeout after %0d cycles", nm, budget);
      end
   endtask

   task automatic start_seq(input int te, input int tg, input int nf);
      T_EXP = te; T_GAP = tg; NUM_FRAME = nf;
      start_i = 1;
      @(negedge CLK);
      start_i = 0;
   endtask

   initial begin
      logic [31:0] t0;
      rst = 1; start_i = 0; stop_i = 0; ro_on = 1;
      T_EXP = 0; T_GAP = 0; NUM_FRAME = 0;
      repeat (3) @(negedge CLK);
      chk("reset_flags", {27'b0, trigger_o, exp_active, seq_busy, seq_done, ack_err}, 0);
      chk("reset_cnt", frame_cnt, 0);
      rst = 0;
      @(negedge CLK);
      // basic frames
      q.push_back('{2, 0, 2, 5});
      start_seq(5, 3, 2);
      chk("start_latency", {30'b0, exp_active, seq_busy}, 3);
      wait_for(0, 200, "basic_done");
      repeat (3) @(negedge CLK);
      // zero parameters
      q.push_back('{3, 0, 3, 1});
      start_seq(0, 0, 3);
      wait_for(2, 50, "zero_busy_rise");
      wait_for(3, 50, "zero_busy_fall");
      @(negedge CLK);
      chk("zero_reexpose", {31'b0, exp_active}, 1);
      wait_for(0, 200, "zero_done");
      repeat (3) @(negedge CLK);
      // continuous with stop during readout of frame 4
      q.push_back('{4, 0, 4, 3});
      start_seq(3, 2, 0);
      for (int i = 0; i < 4; i++) begin
         wait_for(3, 50, "cont_busy_low");
         wait_for(2, 50, "cont_busy_rise");
      end
      @(negedge CLK);
      stop_i = 1;
      @(negedge CLK);
      stop_i = 0;
      wait_for(0, 100, "cont_done");
      t0 = trig_total;
      repeat (30) @(negedge CLK);
      chk("no_extra_trig", trig_total, t0);
      // abort during exposure
      q.push_back('{0, 0, 0, 0});
      start_seq(100, 0, 0);
      repeat (10) @(negedge CLK);
      stop_i = 1;
      @(negedge CLK);
      stop_i = 0;
      chk("abort_idle", {30'b0, seq_busy, seq_done}, 1);
      repeat (3) @(negedge CLK);
      // ack timeout
      ro_on = 0;
      q.push_back('{0, 1, 1, 2});
      start_seq(2, 0, 1);
      wait_for(1, 20, "to_trig");
      repeat (16) @(negedge CLK);
      chk("ack_before_timeout", {31'b0, ack_err}, 0);
      @(negedge CLK);
      chk("ack_at_timeout", {31'b0, ack_err}, 1);
      repeat (5) @(negedge CLK);
      chk("ack_sticky", {31'b0, ack_err}, 1);
      ro_on = 1;
      q.push_back('{1, 0, 1, 2});
      start_seq(2, 0, 1);
      chk("ack_cleared", {31'b0, ack_err}, 0);
      wait_for(0, 100, "retry_done");
      repeat (3) @(negedge CLK);
      // reset mid-readout of frame 2, then a clean run
      start_seq(4, 1, 3);
      wait_for(2, 50, "rr_rise1");
      wait_for(3, 50, "rr_fall1");
      wait_for(2, 50, "rr_rise2");
      @(negedge CLK);
      chk("rr_cnt_before", frame_cnt, 1);
      rst = 1;
      @(negedge CLK);
      rst = 0;
      chk("rr_flags", {27'b0, trigger_o, exp_active, seq_busy, seq_done, ack_err}, 0);
      chk("rr_cnt", frame_cnt, 0);
      repeat (3) @(negedge CLK);
      q.push_back('{3, 0, 3, 4});
      start_seq(4, 1, 3);
      wait_for(0, 300, "rr_restart_done");
      repeat (5) @(negedge CLK);
      chk("sb_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
